// File: rtl/uart_frame_parser.sv
// uart_frame_parser: extracts 55 AA LEN CMD PAYLOAD CSUM frames from a received byte stream,
// buffers the payload and reports good frames or drop reasons.
module uart_frame_parser #(
    parameter int MAX_LEN        = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 104160
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic [7:0]        rx_data,
    input  logic              po_flag,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [ADDR_W:0]   frame_len,
    input  logic [ADDR_W-1:0] pl_raddr,
    output logic [7:0]        pl_rdata,
    output logic              frame_err,
    output logic [1:0]        err_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_HDR2, S_LEN, S_CMD, S_DATA, S_CSUM} state_t;

    state_t            state_q, state_d;
    logic [7:0]        csum_q, csum_d, cmd_q, cmd_d, fcmd_q, fcmd_d;
    logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d, flen_q, flen_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [1:0]        code_q, code_d;
    logic              valid_q, valid_d, err_q, err_d, buf_we;
    logic [7:0]        pl_buf_q [2**ADDR_W];

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= S_IDLE;
            csum_q  <= '0;
            cmd_q   <= '0;
            fcmd_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            flen_q  <= '0;
            tmo_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            csum_q  <= csum_d;
            cmd_q   <= cmd_d;
            fcmd_q  <= fcmd_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            flen_q  <= flen_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Payload storage is deliberately not reset; it only holds data of the latest frame.
    always_ff @(posedge sclk) begin
        if (buf_we) pl_buf_q[idx_q[ADDR_W-1:0]] <= rx_data;
    end

    always_comb begin
        state_d = state_q;
        csum_d  = csum_q;
        cmd_d   = cmd_q;
        fcmd_d  = fcmd_q;
        idx_d   = idx_q;
        len_d   = len_q;
        flen_d  = flen_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        buf_we  = 1'b0;
        tmo_d   = (po_flag || state_q == S_IDLE) ? '0 : (tmo_q == TMAX ? tmo_q : tmo_q + 1'b1);
        if (po_flag) begin
            case (state_q)
                S_IDLE: state_d = (rx_data == 8'h55) ? S_HDR2 : S_IDLE;
                S_HDR2: state_d = (rx_data == 8'hAA) ? S_LEN : (rx_data == 8'h55) ? S_HDR2 : S_IDLE;
                S_LEN: begin
                    if (rx_data != 8'h00 && rx_data <= LEN_MAX) begin
                        len_d   = rx_data[ADDR_W:0];
                        csum_d  = rx_data;
                        idx_d   = '0;
                        state_d = S_CMD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_IDLE;
                    end
                end
                S_CMD: begin
                    cmd_d   = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    buf_we  = 1'b1;
                    csum_d  = csum_q + rx_data;
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q + 1'b1 == len_q) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (rx_data == csum_q) begin
                        valid_d = 1'b1;
                        fcmd_d  = cmd_q;
                        flen_d  = len_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMAX) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = S_IDLE;
        end
    end

    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign frame_cmd   = fcmd_q;
    assign frame_len   = flen_q;
    assign err_code    = code_q;
    assign pl_rdata    = pl_buf_q[pl_raddr];
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: table vectors, hand corner sequences and random traffic
// checked against a byte-list reference model of the frame format.
module tb_uart_frame_parser;
    localparam int MAXL = 16;
    localparam int AW = 4;
    localparam int T = 40;

    logic       sclk = 1'b0;
    logic       srst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       po_flag = 1'b0;
    logic [AW-1:0] pl_raddr = '0;
    logic       frame_valid, frame_err;
    logic [7:0] frame_cmd, pl_rdata;
    logic [AW:0] frame_len;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    uart_frame_parser #(.MAX_LEN(MAXL), .ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
        .sclk(sclk), .srst(srst), .rx_data(rx_data), .po_flag(po_flag),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
        .pl_raddr(pl_raddr), .pl_rdata(pl_rdata), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the partial frame is kept as a plain list of received bytes.
    logic [7:0] frm[$];
    int         gap = 0;
    logic       ev = 0, ee = 0;
    logic [1:0] ecode = 0;
    logic [7:0] ecmd = 0;
    logic [4:0] elen = 0;
    logic [7:0] mbuf [16];
    bit         mknown [16];

    always @(posedge sclk) begin
        int n, s;
        n = frm.size();
        ev = 0;
        ee = 0;
        if (srst) begin
            frm.delete();
            gap = 0; ecode = 0; ecmd = 0; elen = 0;
        end else if (po_flag) begin
            gap = 0;
            if (n == 0) begin
                if (rx_data == 8'h55) frm.push_back(rx_data);
            end else if (n == 1) begin
                if (rx_data == 8'hAA) frm.push_back(rx_data);
                else if (rx_data != 8'h55) frm.delete();
            end else if (n == 2) begin
                if (rx_data >= 1 && rx_data <= MAXL) frm.push_back(rx_data);
                else begin ee = 1; ecode = 1; frm.delete(); end
            end else if (n == 3) begin
                frm.push_back(rx_data);
            end else if (n < 4 + int'(frm[2])) begin
                mbuf[n-4] = rx_data;
                mknown[n-4] = 1;
                frm.push_back(rx_data);
            end else begin
                s = 0;
                for (int i = 2; i < n; i++) s += frm[i];
                if (rx_data == 8'(s)) begin ev = 1; ecmd = frm[3]; elen = 5'(frm[2]); end
                else begin ee = 1; ecode = 2; end
                frm.delete();
            end
        end else if (n != 0) begin
            if (gap == T) begin ee = 1; ecode = 3; frm.delete(); gap = 0; end
            else gap++;
        end else gap = 0;
    end

    always @(negedge sclk) begin
        chk("m_valid", {7'b0, frame_valid}, {7'b0, ev});
        chk("m_err", {7'b0, frame_err}, {7'b0, ee});
        chk("m_code", {6'b0, err_code}, {6'b0, ecode});
        chk("m_cmd", frame_cmd, ecmd);
        chk("m_len", {3'b0, frame_len}, {3'b0, elen});
        if (mknown[pl_raddr]) chk("m_rdata", pl_rdata, mbuf[pl_raddr]);
    end

    // All stimulus steps keep the driver aligned one time unit after a rising edge.
    task automatic idle(input int k);
        repeat (k) begin
            @(posedge sclk); #1;
            pl_raddr = AW'($urandom_range(0, 15));
        end
    endtask

    task automatic put(input logic [7:0] b);
        po_flag = 1; rx_data = b;
        @(posedge sclk); #1;
        po_flag = 0; rx_data = 8'($urandom);
        pl_raddr = AW'($urandom_range(0, 15));
    endtask

    task automatic put_frame(input int kind);
        logic [7:0] q[$];
        int len, s, k;
        len = $urandom_range(1, MAXL);
        q = '{8'h55, 8'hAA, 8'(len), 8'($urandom)};
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        s = 0;
        for (int i = 2; i < q.size(); i++) s += q[i];
        q.push_back(8'(s));
        if (kind == 1) q[q.size()-1] = q[q.size()-1] + 8'd1;
        if (kind == 2) q = '{8'h55, 8'hAA, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255))};
        if (kind == 3) q = '{8'($urandom_range(0, 3) == 0 ? 8'h55 : 8'($urandom))};
        k = (kind == 4) ? $urandom_range(1, len + 4) : q.size();
        for (int i = 0; i < k; i++) begin
            put(q[i]);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        if (kind == 4) idle(T + 2);
    endtask

    typedef struct {
        int          n;
        logic [95:0] b;
        logic        v;
        logic        e;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [4:0]  len;
    } vec_t;
    vec_t tbl [6];

    initial begin
        tbl[0] = '{8, 96'h55AA031001020319, 1'b1, 1'b0, 2'd0, 8'h10, 5'd3};
        tbl[1] = '{8, 96'h55AA031001020318, 1'b0, 1'b1, 2'd2, 8'h10, 5'd3};
        tbl[2] = '{3, 96'h55AA00, 1'b0, 1'b1, 2'd1, 8'h10, 5'd3};
        tbl[3] = '{3, 96'h55AA11, 1'b0, 1'b1, 2'd1, 8'h10, 5'd3};
        tbl[4] = '{6, 96'h55AA0140ABEC, 1'b1, 1'b0, 2'd1, 8'h40, 5'd1};
        tbl[5] = '{8, 96'h125555AA01207E9F, 1'b1, 1'b0, 2'd1, 8'h20, 5'd1};
        idle(3);
        chk("rst_valid", {7'b0, frame_valid}, 8'h00);
        chk("rst_err", {7'b0, frame_err}, 8'h00);
        chk("rst_cmd", frame_cmd, 8'h00);
        chk("rst_len", {3'b0, frame_len}, 8'h00);
        chk("rst_code", {6'b0, err_code}, 8'h00);
        srst = 0;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < tbl[i].n; j++) put(tbl[i].b[8*(tbl[i].n-1-j) +: 8]);
            chk($sformatf("tbl%0d_valid", i), {7'b0, frame_valid}, {7'b0, tbl[i].v});
            chk($sformatf("tbl%0d_err", i), {7'b0, frame_err}, {7'b0, tbl[i].e});
            chk($sformatf("tbl%0d_code", i), {6'b0, err_code}, {6'b0, tbl[i].code});
            chk($sformatf("tbl%0d_cmd", i), frame_cmd, tbl[i].cmd);
            chk($sformatf("tbl%0d_len", i), {3'b0, frame_len}, {3'b0, tbl[i].len});
            idle(1);
        end
        foreach (tbl[0].b[k]) if (k < 8) begin end
        put(8'h55); put(8'hAA); put(8'h03); put(8'h10); put(8'h01); put(8'h02); put(8'h03); put(8'h19);
        for (int a = 0; a < 3; a++) begin
            pl_raddr = AW'(a); #1;
            chk($sformatf("pl%0d", a), pl_rdata, 8'(a + 1));
        end
        idle(2);
        put(8'h55); put(8'hAA); put(8'h02); put(8'h30);
        idle(T);
        chk("tmo_early", {7'b0, frame_err}, 8'h00);
        idle(1);
        chk("tmo_err", {7'b0, frame_err}, 8'h01);
        chk("tmo_code", {6'b0, err_code}, 8'h03);
        idle(2);
        put(8'h55); put(8'hAA); put(8'h02); put(8'h30);
        idle(T);
        put(8'h11);
        chk("tmo_race_err", {7'b0, frame_err}, 8'h00);
        idle(T);
        put(8'h22);
        chk("tmo_race2_err", {7'b0, frame_err}, 8'h00);
        put(8'h65);
        chk("tmo_race_valid", {7'b0, frame_valid}, 8'h01);
        chk("tmo_race_cmd", frame_cmd, 8'h30);
        idle(2);
        put(8'h55); put(8'hAA); put(8'h02); put(8'h50);
        srst = 1; idle(1); srst = 0;
        chk("srst_err", {7'b0, frame_err}, 8'h00);
        chk("srst_valid", {7'b0, frame_valid}, 8'h00);
        chk("srst_cmd", frame_cmd, 8'h00);
        idle(1);
        put(8'h55); put(8'hAA); put(8'h02); put(8'h50); put(8'h01); put(8'h02); put(8'h55);
        chk("post_srst_valid", {7'b0, frame_valid}, 8'h01);
        chk("post_srst_len", {3'b0, frame_len}, 8'h02);
        put(8'h55); put(8'hAA); put(8'h01); put(8'h21); put(8'h05); put(8'h27);
        chk("b2b_a_valid", {7'b0, frame_valid}, 8'h01);
        put(8'h55); put(8'hAA); put(8'h01); put(8'h22); put(8'h06); put(8'h29);
        chk("b2b_b_valid", {7'b0, frame_valid}, 8'h01);
        chk("b2b_b_cmd", frame_cmd, 8'h22);
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 4) put_frame(kind);
            else if (kind == 5) begin srst = 1; idle(1); srst = 0; end
            else put_frame(0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
